// File: rtl/dmem_pkg.sv
// Shared encodings for the sized data memory: access sizes, FSM states, latched request.
// The wait-counter width macro keeps a 1-bit counter legal when WAIT_STATES is 0.
`ifndef DMEM_PKG_SV
`define DMEM_PKG_SV
`define DMEM_CNT_W(ws) (((ws) < 1) ? 1 : $clog2((ws) + 1))

package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    typedef struct packed {
        logic        we;
        size_e       size;
        logic        sign_ext;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

`endif

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: alignment check, byte enables, store replication
// and load extraction/extension for little-endian 32-bit words.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic        misalign,
    output logic [3:0]  byte_en,
    output logic [31:0] wlanes,
    output logic [31:0] rdata
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        rbyte    = rword[{offset, 3'b000} +: 8];
        rhalf    = offset[1] ? rword[31:16] : rword[15:0];
        misalign = 1'b0;
        byte_en  = 4'b0000;
        wlanes   = wdata;
        rdata    = rword;
        case (size)
            SIZE_BYTE: begin
                byte_en = 4'b0001 << offset;
                wlanes  = {4{wdata[7:0]}};
                rdata   = {{24{sign_ext & rbyte[7]}}, rbyte};
            end
            SIZE_HALF: begin
                misalign = offset[0];
                byte_en  = offset[0] ? 4'b0000 : (4'b0011 << offset);
                wlanes   = {2{wdata[15:0]}};
                rdata    = {{16{sign_ext & rhalf[15]}}, rhalf};
            end
            SIZE_WORD: begin
                misalign = |offset;
                byte_en  = (|offset) ? 4'b0000 : 4'b1111;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_memory_sized.sv
// Word-organised data memory with req/ready/ack handshake, WAIT_STATES delay and
// misalignment errors. Define DMEM_ACCESS_COUNT_EN to add saturating access counters.
module data_memory_sized
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 7,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           write_data,
    output logic                  ready,
    output logic                  ack,
    output logic                  error,
    output logic [31:0]           read_data
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count,
    output logic [15:0]           err_count
`endif
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
    localparam int CW    = `DMEM_CNT_W(WAIT_STATES);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    dmem_req_t             lat_q, lat_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  err_q, err_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  mem_we;

    // Initial contents seed words 0..2 for simulation; reset never clears the array.
    logic [31:0] mem [DEPTH] = '{0: 32'd2, 1: 32'd3, 2: 32'd4, default: 32'd0};

    // One aligner: live inputs while IDLE (error decision), latched request afterwards.
    size_e       al_size;
    logic [1:0]  al_offset;
    logic        al_sign_ext;
    logic        al_misalign;
    logic [3:0]  al_be;
    logic [31:0] al_wlanes;
    logic [31:0] al_rdata;

    assign al_size     = (state_q == IDLE) ? size_e'(size) : lat_q.size;
    assign al_offset   = (state_q == IDLE) ? address[1:0] : addr_q[1:0];
    assign al_sign_ext = lat_q.sign_ext;

    dmem_lane_align u_align (
        .size     (al_size),
        .offset   (al_offset),
        .sign_ext (al_sign_ext),
        .wdata    (lat_q.wdata),
        .rword    (mem[addr_q[ADDR_WIDTH-1:2]]),
        .misalign (al_misalign),
        .byte_en  (al_be),
        .wlanes   (al_wlanes),
        .rdata    (al_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        addr_d  = addr_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    lat_d  = '{we: we, size: size_e'(size), sign_ext: sign_ext, wdata: write_data};
                    addr_d = address;
                    if (al_misalign) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    if (lat_q.we) mem_we  = 1'b1;
                    else          rdata_d = al_rdata;
                end
            end
            RESP: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (al_be[k]) mem[addr_q[ADDR_WIDTH-1:2]][8*k +: 8] <= al_wlanes[8*k +: 8];
            end
        end
    end

    assign ready     = (state_q == IDLE);
    assign ack       = (state_q == RESP);
    assign error     = err_q;
    assign read_data = rdata_q;

`ifdef DMEM_ACCESS_COUNT_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] er_cnt_q, er_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        er_cnt_d = er_cnt_q;
        if (state_q == RESP) begin
            if (err_q) begin
                if (er_cnt_q != 16'hFFFF) er_cnt_d = er_cnt_q + 16'd1;
            end else if (lat_q.we) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
            end else begin
                if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            er_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            er_cnt_q <= er_cnt_d;
        end
    end

    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;
    assign err_count = er_cnt_q;
`endif

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench: one instance with WAIT_STATES=0, one with WAIT_STATES=3,
// expected values hand-computed from the initial words 2,3,4.
module tb_data_memory_sized;

    logic        clk;
    logic        rst [2];
    logic        req [2];
    logic        we [2];
    logic [1:0]  size [2];
    logic        sign_ext [2];
    logic [6:0]  address [2];
    logic [31:0] write_data [2];
    logic        ready [2];
    logic        ack [2];
    logic        error [2];
    logic [31:0] read_data [2];
`ifdef DMEM_ACCESS_COUNT_EN
    logic [15:0] rd_count [2];
    logic [15:0] wr_count [2];
    logic [15:0] err_count [2];
    int          exp_rd [2];
    int          exp_wr [2];
    int          exp_er [2];
`endif

    int n_chk  = 0;
    int n_fail = 0;

    data_memory_sized #(.ADDR_WIDTH(7), .WAIT_STATES(0)) u_ws0 (
        .clock(clk), .reset(rst[0]), .req(req[0]), .we(we[0]), .size(size[0]),
        .sign_ext(sign_ext[0]), .address(address[0]), .write_data(write_data[0]),
        .ready(ready[0]), .ack(ack[0]), .error(error[0]), .read_data(read_data[0])
`ifdef DMEM_ACCESS_COUNT_EN
        , .rd_count(rd_count[0]), .wr_count(wr_count[0]), .err_count(err_count[0])
`endif
    );

    data_memory_sized #(.ADDR_WIDTH(7), .WAIT_STATES(3)) u_ws3 (
        .clock(clk), .reset(rst[1]), .req(req[1]), .we(we[1]), .size(size[1]),
        .sign_ext(sign_ext[1]), .address(address[1]), .write_data(write_data[1]),
        .ready(ready[1]), .ack(ack[1]), .error(error[1]), .read_data(read_data[1])
`ifdef DMEM_ACCESS_COUNT_EN
        , .rd_count(rd_count[1]), .wr_count(wr_count[1]), .err_count(err_count[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request at a negedge, then count cycles to ack (bounded).
    task automatic access(input int d, input string tag, input logic w, input logic [1:0] sz,
                          input logic sx, input logic [6:0] a, input logic [31:0] wd,
                          input int exp_lat, input logic exp_err, input logic [31:0] exp_rd,
                          input bit toggle);
        int lat;
        bit done;
        lat  = 0;
        done = 0;
        @(negedge clk);
        check({tag, ".ready_idle"}, ready[d], 1'b1);
        req[d] = 1'b1; we[d] = w; size[d] = sz; sign_ext[d] = sx;
        address[d] = a; write_data[d] = wd;
        while (!done) begin
            @(negedge clk);
            lat++;
            check({tag, ".ready_busy"}, ready[d], 1'b0);
            if (ack[d] || lat >= 20) begin
                req[d] = 1'b0;
                done   = 1;
            end else if (toggle) begin
                req[d] = 1'b1; we[d] = 1'b1; size[d] = 2'b10;
                address[d] = 7'($urandom) & 7'h7C; write_data[d] = 32'hBAD0BAD0;
            end else begin
                req[d] = 1'b0;
            end
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".error"}, error[d], exp_err);
        check({tag, ".rdata"}, read_data[d], exp_rd);
`ifdef DMEM_ACCESS_COUNT_EN
        if (exp_err) exp_er[d]++;
        else if (w)  exp_wr[d]++;
        else         exp_rd[d]++;
`endif
    endtask

    initial begin
        bit seen_ack;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; size[i] = 2'b00;
            sign_ext[i] = 1'b0; address[i] = '0; write_data[i] = '0;
`ifdef DMEM_ACCESS_COUNT_EN
            exp_rd[i] = 0; exp_wr[i] = 0; exp_er[i] = 0;
`endif
        end
        repeat (2) @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("reset.ready", ready[i], 1'b1);
            check("reset.ack", ack[i], 1'b0);
            check("reset.error", error[i], 1'b0);
            check("reset.rdata", read_data[i], 32'h0);
        end

        // WAIT_STATES = 0
        access(0, "lw00", 0, 2'b10, 0, 7'h00, 0, 2, 0, 32'h00000002, 0);
        access(0, "lw04", 0, 2'b10, 0, 7'h04, 0, 2, 0, 32'h00000003, 0);
        access(0, "sb09", 1, 2'b00, 0, 7'h09, 32'hFFFFFF85, 2, 0, 32'h00000003, 0);
        access(0, "lb09", 0, 2'b00, 1, 7'h09, 0, 2, 0, 32'hFFFFFF85, 0);
        access(0, "lbu09", 0, 2'b00, 0, 7'h09, 0, 2, 0, 32'h00000085, 0);
        access(0, "lw08", 0, 2'b10, 1, 7'h08, 0, 2, 0, 32'h00008504, 0);
        access(0, "sw0c", 1, 2'b10, 0, 7'h0C, 32'h12345678, 2, 0, 32'h00008504, 0);
        access(0, "sh0e", 1, 2'b01, 0, 7'h0E, 32'h1234BEEF, 2, 0, 32'h00008504, 0);
        access(0, "lw0c", 0, 2'b10, 0, 7'h0C, 0, 2, 0, 32'hBEEF5678, 0);
        access(0, "lh0e", 0, 2'b01, 1, 7'h0E, 0, 2, 0, 32'hFFFFBEEF, 0);
        access(0, "lhu0c", 0, 2'b01, 0, 7'h0C, 0, 2, 0, 32'h00005678, 0);
        access(0, "lw05_mis", 0, 2'b10, 0, 7'h05, 0, 1, 1, 32'h00005678, 0);
        access(0, "sh03_mis", 1, 2'b01, 0, 7'h03, 32'hFFFF, 1, 1, 32'h00005678, 0);
        access(0, "rsvd_size", 0, 2'b11, 0, 7'h00, 0, 1, 1, 32'h00005678, 0);
        access(0, "lw04_again", 0, 2'b10, 0, 7'h04, 0, 2, 0, 32'h00000003, 0);
        access(0, "lw00_again", 0, 2'b10, 0, 7'h00, 0, 2, 0, 32'h00000002, 0);
        access(0, "sb7f", 1, 2'b00, 0, 7'h7F, 32'h000000AA, 2, 0, 32'h00000002, 0);
        access(0, "lbu7f", 0, 2'b00, 0, 7'h7F, 0, 2, 0, 32'h000000AA, 0);
        access(0, "lw7c", 0, 2'b10, 0, 7'h7C, 0, 2, 0, 32'hAA000000, 0);

        // WAIT_STATES = 3, busy-cycle inputs toggled
        access(1, "ws3_lw08", 0, 2'b10, 0, 7'h08, 0, 5, 0, 32'h00000004, 1);
        access(1, "ws3_lw00", 0, 2'b10, 0, 7'h00, 0, 5, 0, 32'h00000002, 0);

        // Reset in first WAIT cycle discards the store
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; size[1] = 2'b10; address[1] = 7'h00;
        write_data[1] = 32'hDEADBEEF;
        @(negedge clk);
        req[1] = 1'b0; rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
`ifdef DMEM_ACCESS_COUNT_EN
        exp_rd[1] = 0; exp_wr[1] = 0; exp_er[1] = 0;
`endif
        seen_ack = 0;
        repeat (8) begin
            if (ack[1]) seen_ack = 1;
            @(negedge clk);
        end
        check("ws3_rst.no_ack", seen_ack, 1'b0);
        check("ws3_rst.rdata_cleared", read_data[1], 32'h0);
        access(1, "ws3_lw00_post", 0, 2'b10, 0, 7'h00, 0, 5, 0, 32'h00000002, 0);

`ifdef DMEM_ACCESS_COUNT_EN
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("cnt.rd", rd_count[i], exp_rd[i]);
            check("cnt.wr", wr_count[i], exp_wr[i]);
            check("cnt.err", err_count[i], exp_er[i]);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
